// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported fixed-latency memory between the fetch
//            stage and the memory stage. Grants one requester at a time,
//            holds the port for MEM_LATENCY cycles, returns registered read
//            data with a one-cycle ready pulse and drives the stall signals.
// Options  : MEM_ARB_RR_EN - round-robin priority between fetch and data
//            (default build: strict data-over-fetch priority).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter start value: the access ends when the counter reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic              w_pick_d;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_busy;
  logic              w_last;

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_last = w_busy && (r_cnt == 4'd0);

`ifdef MEM_ARB_RR_EN
  // 1 = data stage won the most recent grant, 0 = fetch (reset value)
  logic r_last_grant;

  // Remember the most recent winner so contention alternates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b0;
    end else if (w_grant_d) begin
      r_last_grant <= 1'b1;
    end else if (w_grant_i) begin
      r_last_grant <= 1'b0;
    end
  end

  // Under contention the requester that did not win last time goes first
  assign w_pick_d = dm_req & (~if_req | ~r_last_grant);
`else
  // Data accesses always take precedence over instruction fetch
  assign w_pick_d = dm_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and grant decisions; grants are only made from IDLE
  always_comb begin
    w_state_next = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d    = 1'b1;
          w_state_next = BUSY_D;
        end else if (if_req) begin
          w_grant_i    = 1'b1;
          w_state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (r_cnt == 4'd0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Port registers are loaded only at the grant edge, then held for the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_d) begin
      r_cnt   <= CNT_INIT;
      r_we    <= dm_we;
      r_addr  <= dm_addr;
      r_wdata <= dm_wdata;
    end else if (w_grant_i) begin
      r_cnt   <= CNT_INIT;
      r_we    <= 1'b0;
      r_addr  <= if_addr;
    end else if (w_busy && (r_cnt != 4'd0)) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Capture read data in the last enabled cycle and raise ready for DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
    end else begin
      r_if_ready <= w_last && (r_state == BUSY_I);
      r_dm_ready <= w_last && (r_state == BUSY_D);
      if (w_last && (r_state == BUSY_I)) begin
        r_if_rdata <= mem_rdata;
      end
      if (w_last && (r_state == BUSY_D) && !r_we) begin
        r_dm_rdata <= mem_rdata;
      end
    end
  end

  // Write enable is gated so a store never writes outside its enabled window
  assign mem_en    = w_busy;
  assign mem_we    = w_busy & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;

  assign stall_f   = if_req & ~r_if_ready;
  assign stall_m   = dm_req & ~r_dm_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//            model (grant cycle + latency arithmetic) predicts every output.
//            Honours MEM_ARB_RR_EN when the design is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main instance (MEM_LATENCY = 2)
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;

  // Second instance (MEM_LATENCY = 1)
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_stall_f, b_stall_m;

  int total = 0;
  int bad   = 0;

  // Reference model state: one outstanding access described by its grant cycle
  bit          act;
  int          g;
  bit          own_d;
  logic        we_l;
  logic [31:0] addr_l, wd_l, e_ifr, e_dmr;
  bit          last_d;
  int          k;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_f(b_stall_f), .stall_m(b_stall_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act    = 1'b0;
    g      = 0;
    own_d  = 1'b0;
    we_l   = 1'b0;
    addr_l = '0;
    wd_l   = '0;
    e_ifr  = '0;
    e_dmr  = '0;
    last_d = 1'b0;
    k      = 0;
  endtask

  // Expected outputs for cycle k follow from the grant cycle g alone
  task automatic model_check();
    bit en, rdy;
    en  = act && (k >= g + 1) && (k <= g + L);
    rdy = act && (k == g + L + 1);
    chk("mem_en",   {31'd0, mem_en},   {31'd0, en});
    chk("mem_we",   {31'd0, mem_we},   {31'd0, en && own_d && we_l});
    if (en) chk("mem_addr", mem_addr, addr_l);
    if (en && own_d && we_l) chk("mem_wdata", mem_wdata, wd_l);
    chk("if_ready", {31'd0, if_ready}, {31'd0, rdy && !own_d});
    chk("dm_ready", {31'd0, dm_ready}, {31'd0, rdy && own_d});
    chk("if_rdata", if_rdata, e_ifr);
    chk("dm_rdata", dm_rdata, e_dmr);
    chk("stall_f",  {31'd0, stall_f},  {31'd0, if_req && !(rdy && !own_d)});
    chk("stall_m",  {31'd0, stall_m},  {31'd0, dm_req && !(rdy && own_d)});
  endtask

  // Called at the clock edge, while the cycle-k inputs are still applied
  task automatic model_update();
    bit free, pick_d;
    if (act && (k == g + L)) begin
      if (!own_d) e_ifr = mem_rdata;
      else if (!we_l) e_dmr = mem_rdata;
    end
    free = !act || (k >= g + L + 2);
`ifdef MEM_ARB_RR_EN
    pick_d = dm_req && (!if_req || !last_d);
`else
    pick_d = dm_req;
`endif
    if (free && pick_d) begin
      act = 1'b1; g = k; own_d = 1'b1; we_l = dm_we;
      addr_l = dm_addr; wd_l = dm_wdata; last_d = 1'b1;
    end else if (free && if_req) begin
      act = 1'b1; g = k; own_d = 1'b0; we_l = 1'b0;
      addr_l = if_addr; last_d = 1'b0;
    end
    k++;
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [31:0] rd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
    dm_addr = da; dm_wdata = dwd; mem_rdata = rd;
  endtask

  task automatic drive();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0;
    b_dm_addr = 0; b_dm_wdata = 0; b_mem_rdata = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en",    {31'd0, mem_en},   32'd0);
    chk("rst_mem_addr",  mem_addr,          32'd0);
    chk("rst_mem_wdata", mem_wdata,         32'd0);
    chk("rst_if_rdata",  if_rdata,          32'd0);
    chk("rst_dm_ready",  {31'd0, dm_ready}, 32'd0);
    chk("rst_b_mem_en",  {31'd0, b_mem_en}, 32'd0);
    #1 rst_n = 1'b1;

    // MEM_LATENCY=1 fetch: one enable cycle, ready on the next
    for (int c = 0; c < 4; c++) begin
      b_if_req    = (c < 3);
      b_if_addr   = 32'h0;
      b_mem_rdata = (c == 1) ? 32'h2000_0001 : $urandom;
      drive();
      chk("l1_mem_en",   {31'd0, b_mem_en},   {31'd0, c == 1});
      chk("l1_if_ready", {31'd0, b_if_ready}, {31'd0, c == 2});
      if (c == 1) chk("l1_mem_addr", b_mem_addr, 32'h0);
      if (c == 2) chk("l1_if_rdata", b_if_rdata, 32'h2000_0001);
      if (c == 0) chk("l1_stall_f", {31'd0, b_stall_f}, 32'd1);
      if (c == 3) begin
        chk("l1_idle_misc", {b_dm_ready, b_mem_we, b_stall_m, b_stall_f}, 32'd0);
        chk("l1_dm_rdata", b_dm_rdata ^ b_mem_wdata, 32'd0);
      end
      adv();
    end

    // Load: address sampled at grant only, data returned with dm_ready at cycle 3
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, c < 4, 0, (c == 0) ? 32'h40 : $urandom, 0,
             (c == 2) ? 32'h1234_5678 : $urandom);
      drive();
      if (c == 1) chk("ld_mem_addr", mem_addr, 32'h40);
      if (c == 3) chk("ld_dm_rdata", dm_rdata, 32'h1234_5678);
      if (c == 2) chk("ld_stall_m", {31'd0, stall_m}, 32'd1);
      adv();
    end

    // Store: write held for two cycles, load data untouched
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, c < 4, c == 0, 32'h80, (c == 0) ? 32'hCAFE_F00D : $urandom, $urandom);
      drive();
      if (c == 1 || c == 2) chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      if (c == 3) chk("st_dm_ready", {31'd0, dm_ready}, 32'd1);
      if (c == 4) chk("st_dm_rdata", dm_rdata, 32'h1234_5678);
      adv();
    end

    // Contention: both request at cycle 0
    for (int c = 0; c < 9; c++) begin
      set_in(c < 8, 32'h100, c < 4, 0, 32'h44, 0, $urandom);
      drive();
`ifndef MEM_ARB_RR_EN
      if (c == 3) chk("ct_dm_ready", {31'd0, dm_ready}, 32'd1);
      if (c == 4) chk("ct_stall_f4", {31'd0, stall_f}, 32'd1);
      if (c == 5) chk("ct_mem_addr", mem_addr, 32'h100);
      if (c == 7) chk("ct_if_ready", {31'd0, if_ready}, 32'd1);
`endif
      adv();
    end

    // Held data request: no re-grant in DONE, second ready at cycle 7
    for (int c = 0; c < 9; c++) begin
      set_in(0, 0, c < 8, 0, 32'h48, 0, $urandom);
      drive();
      if (c == 4) chk("hd_no_grant", {31'd0, mem_en}, 32'd0);
      if (c == 7) chk("hd_dm_ready2", {31'd0, dm_ready}, 32'd1);
      adv();
    end

    // Asynchronous reset in the middle of a load
    set_in(0, 0, 1, 0, 32'h200, 0, $urandom);
    drive(); adv();
    set_in(0, 0, 1, 0, 32'h200, 0, $urandom);
    drive(); adv();
    set_in(0, 0, 0, 0, 0, 0, 32'hDEAD);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_mem_en",   {31'd0, mem_en},   32'd0);
    chk("ar_mem_we",   {31'd0, mem_we},   32'd0);
    chk("ar_mem_addr", mem_addr,          32'd0);
    chk("ar_dm_rdata", dm_rdata,          32'd0);
    chk("ar_if_rdata", if_rdata,          32'd0);
    @(posedge clk);
    #1;
    chk("ar_no_ready", {31'd0, dm_ready}, 32'd0);
    #2 rst_n = 1'b1;

    // After release the arbiter grants from IDLE again
    for (int c = 0; c < 5; c++) begin
      set_in(c < 4, 32'h300, 0, 0, 0, 0, (c == 2) ? 32'hBEEF_0001 : $urandom);
      drive();
      if (c == 3) chk("ar_if_rdata2", if_rdata, 32'hBEEF_0001);
      adv();
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
      drive();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined CPU. It grants one requester at a time, drives the memory port for the access duration, returns read data with a one-cycle ready pulse, and produces the stall signals that freeze the fetch stage and the EX/MEM pipeline register while an access is pending.

## Interface
- MEM_LATENCY, 2: cycles the memory port is held enabled per access; legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch requests an instruction read.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  registered instruction word.
- if_ready  out  1  one-cycle pulse: fetch access complete.
- dm_req  in  1  memory stage requests an access (mem_to_reg_m | mem_write_m).
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address (alu_result_m).
- dm_wdata  in  DATA_W  store data (write_data_m).
- dm_rdata  out  DATA_W  registered load data.
- dm_ready  out  1  one-cycle pulse: data access complete.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the last enabled cycle.
- stall_f  out  1  if_req & ~if_ready.
- stall_m  out  1  dm_req & ~dm_ready.

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: if dm_req, latch dm_addr/dm_we/dm_wdata into the port registers, load cnt = MEM_LATENCY-1, go to BUSY_D. Otherwise, if if_req, latch if_addr with we=0 and go to BUSY_I. Otherwise stay in IDLE.
- BUSY_x: mem_en=1 and mem_we/addr/wdata come from the latched registers, held stable for the whole state. If cnt≠0, decrement cnt. If cnt==0, capture mem_rdata into if_rdata (BUSY_I) or dm_rdata (BUSY_D, loads only), set the matching ready, and go to DONE.
- DONE: ready high for exactly this cycle, mem_en=0, no grant is made. The requester's pipeline register advances on this edge. Next state is IDLE.
- Stores leave dm_rdata unchanged but still pulse dm_ready.
- Requests are level-sensitive. A request dropped mid-access does not abort it; the access completes and ready still pulses.
- Address and data inputs are sampled only at the grant edge.
- stall_f and stall_m are combinational from the req inputs and the registered ready outputs.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0.
  - Any in-flight access is abandoned with no ready pulse.
- Request seen in IDLE at cycle 0:
  - mem_en high in cycles 1..MEM_LATENCY.
  - ready high in cycle MEM_LATENCY+1.
  - The requester stalls for MEM_LATENCY+1 cycles.
- Minimum spacing between grants is MEM_LATENCY+2 cycles. A request held through DONE is not re-granted in DONE.
- Simultaneous if_req and dm_req in IDLE: dm wins. Fetch stays stalled until its own grant completes.
- MEM_LATENCY=1: a single mem_en cycle, ready on the next cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin priority. A last_grant bit (reset to fetch) records the last winner. When both requests are present in IDLE, the requester that did not win last is granted. A lone request is always granted.
- MEM_ARB_RR_EN undefined: strict data-over-fetch priority as described above. last_grant is not instantiated.

## Test plan
- Reset: assert rst_n=0 mid-BUSY_D, drive mem_rdata=32'hDEAD -> all outputs 0 immediately, no dm_ready pulse, state IDLE after release.
- Load, MEM_LATENCY=2: dm_req=1, dm_we=0, dm_addr=32'h40 at cycle 0, mem_rdata=32'h1234_5678 -> mem_en cycles 1-2 with mem_addr=32'h40; dm_ready cycle 3; dm_rdata=32'h1234_5678; stall_m high cycles 0-2.
- Store: dm_we=1, dm_addr=32'h80, dm_wdata=32'hCAFE_F00D -> mem_we=1 with that data for 2 cycles, dm_ready pulses, dm_rdata unchanged.
- Contention: if_req and dm_req both high at cycle 0 -> data served cycles 1-3, fetch granted cycle 4, if_ready cycle 7. With MEM_ARB_RR_EN and a prior data grant, fetch is served first instead.
- Held request: dm_req kept high through DONE -> no grant in DONE; second grant at cycle 4, second dm_ready at cycle 7.
- MEM_LATENCY=1: fetch with if_addr=32'h0, mem_rdata=32'h2000_0001 -> mem_en cycle 1 only, if_ready cycle 2, if_rdata=32'h2000_0001.
